// File: rtl/rv32_cpu_pkg.sv
// Shared CPU package: co-processor dispatch state encoding and slot indices.
package rv32_cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } cp_state_e;

  localparam int unsigned CP_FPU      = 0;
  localparam int unsigned CP_BITMANIP = 1;
  localparam int unsigned CP_SHIFT    = 2;
  localparam int unsigned CP_CUSTOM   = 3;

endpackage

// File: rtl/rv32_cpu_cp_dispatch_if.sv
// Bundle of CPU-side issue signals and co-processor start/valid signals seen
// by the dispatcher. The slave modport is the dispatcher; the master modport
// is the environment (CPU execute stage plus co-processor array).
interface rv32_cpu_cp_dispatch_if #(
  parameter int XLEN   = 32,
  parameter int NUM_CP = 4
);

  localparam int SEL_W = $clog2(NUM_CP);

  logic                   i_issue;
  logic [SEL_W-1:0]       i_sel;
  logic                   i_abort;
  logic [1:0]             i_cmp;
  logic [XLEN-1:0]        i_rs1;
  logic [XLEN-1:0]        i_rs2;
  logic [XLEN-1:0]        i_rs3;
  logic [NUM_CP-1:0]      o_cp_start;
  logic [1:0]             o_cp_cmp;
  logic [XLEN-1:0]        o_cp_rs1;
  logic [XLEN-1:0]        o_cp_rs2;
  logic [XLEN-1:0]        o_cp_rs3;
  logic [NUM_CP*XLEN-1:0] i_cp_res;
  logic [NUM_CP-1:0]      i_cp_valid;
  logic [XLEN-1:0]        o_res;
  logic                   o_done;
  logic                   o_tmo_err;
  logic                   o_busy;

  modport slave (
    input  i_issue, i_sel, i_abort, i_cmp, i_rs1, i_rs2, i_rs3,
    input  i_cp_res, i_cp_valid,
    output o_cp_start, o_cp_cmp, o_cp_rs1, o_cp_rs2, o_cp_rs3,
    output o_res, o_done, o_tmo_err, o_busy
  );

  modport master (
    output i_issue, i_sel, i_abort, i_cmp, i_rs1, i_rs2, i_rs3,
    output i_cp_res, i_cp_valid,
    input  o_cp_start, o_cp_cmp, o_cp_rs1, o_cp_rs2, o_cp_rs3,
    input  o_res, o_done, o_tmo_err, o_busy
  );

endinterface

// File: rtl/rv32_cpu_cp_dispatch.sv
// Co-processor dispatcher: latches an issued operation, pulses start to the
// selected co-processor, waits for its valid strobe (or a timeout) and returns
// the result to the CPU. All outputs are registered.
module rv32_cpu_cp_dispatch
  import rv32_cpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_CP  = 4,
  parameter int TIMEOUT = 128
) (
  input logic                   i_clk,
  input logic                   i_rstn,
  rv32_cpu_cp_dispatch_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_CP);
  localparam int CNT_W = $clog2(TIMEOUT);

  cp_state_e         state;
  cp_state_e         next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [SEL_W-1:0]  sel_q;
  logic              sel_valid;
  logic              cnt_last;
  logic [XLEN-1:0]   sel_res;

  logic [NUM_CP-1:0] start_d, start_q;
  logic              done_d, done_q;
  logic              tmo_d, tmo_q;
  logic              busy_d, busy_q;
  logic [XLEN-1:0]   res_d, res_q;
  logic [1:0]        cmp_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, rs3_q;

  assign sel_valid = bus.i_cp_valid[sel_q];
  assign sel_res   = bus.i_cp_res[int'(sel_q)*XLEN +: XLEN];
  assign cnt_last  = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Next-state logic; abort overrides every other condition
  always_comb begin
    next_state = state;
    if (bus.i_abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.i_issue) next_state = ST_START;
        ST_START: next_state = ST_WAIT;
        ST_WAIT:  if (sel_valid || cnt_last) next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; valid wins over a same-cycle timeout
  always_comb begin
    start_d = '0;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    res_d   = res_q;
    busy_d  = (next_state != ST_IDLE);
    if (!bus.i_abort) begin
      case (state)
        ST_IDLE: begin
          if (bus.i_issue) start_d = NUM_CP'(1) << bus.i_sel;
        end
        ST_WAIT: begin
          if (sel_valid) begin
            done_d = 1'b1;
            res_d  = sel_res;
          end else if (cnt_last) begin
            tmo_d  = 1'b1;
            res_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      start_q <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      start_q <= start_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      res_q   <= res_d;
    end
  end

  // WAIT cycle counter, cleared in START so each operation gets a full window
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_cnt <= '0;
    end else if (state == ST_START) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && !sel_valid && !cnt_last) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Operand and target latches, loaded only when an issue is accepted
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sel_q <= '0;
      cmp_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
    end else if (state == ST_IDLE && bus.i_issue && !bus.i_abort) begin
      sel_q <= bus.i_sel;
      cmp_q <= bus.i_cmp;
      rs1_q <= bus.i_rs1;
      rs2_q <= bus.i_rs2;
      rs3_q <= bus.i_rs3;
    end
  end

  assign bus.o_cp_start = start_q;
  assign bus.o_cp_cmp   = cmp_q;
  assign bus.o_cp_rs1   = rs1_q;
  assign bus.o_cp_rs2   = rs2_q;
  assign bus.o_cp_rs3   = rs3_q;
  assign bus.o_res      = res_q;
  assign bus.o_done     = done_q;
  assign bus.o_tmo_err  = tmo_q;
  assign bus.o_busy     = busy_q;

endmodule
